// File: rtl/reglk_prog_ctrl_if.sv
// Bus port of the register-lock programming stage.
// The master drives requests and the slave returns grant and response.
interface reglk_prog_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [2:0]  addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/reglk_prog_ctrl.sv
// Register-lock programming stage. It owns the NUM_WORDS x 32 lock-bit array
// that feeds the peripheral write-guards. Bus writes can only set bits. Address 6
// holds a one-shot seal and a status word. The only ways to clear the array are
// rst_i and a key-authenticated JTAG unlock, which has a timeout and a
// permanent lockout after repeated failures.
// Optional feature macro: REGLK_PARITY_EN. It adds a parity bit to each word.
// A parity mismatch sets a sticky error and forces all words to all-ones.
module reglk_prog_ctrl #(
  parameter int unsigned NUM_WORDS      = 6,
  parameter logic [31:0] UNLOCK_KEY     = 32'hA5C3_5A3C,
  parameter int unsigned UNLOCK_TIMEOUT = 16,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  reglk_prog_ctrl_if.slave            bus,
  input  logic                        jtag_unlock_req_i,
  input  logic                        jtag_key_valid_i,
  input  logic [31:0]                 jtag_key_i,
  output logic                        unlock_done_o,
  output logic                        lockout_o,
  output logic                        reglk_parity_err_o,
  output logic [NUM_WORDS-1:0][31:0]  reglk_mem_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_CLEAR   = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam logic [2:0] CTRL_ADDR  = 3'd6;

  localparam int unsigned TW = (UNLOCK_TIMEOUT > 1) ? $clog2(UNLOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(UNLOCK_TIMEOUT - 1);
  localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAILS);

  logic [2:0]                 r_state;
  logic [2:0]                 w_state_nxt;
  logic [TW-1:0]              r_timer;
  logic [TW-1:0]              w_timer_nxt;
  logic [1:0]                 r_fail_cnt;
  logic                       r_need_low;
  logic                       r_seal;
  logic                       r_lockout;
  logic                       r_unlock_done;
  logic [NUM_WORDS-1:0][31:0] r_mem;
  logic [NUM_WORDS-1:0][31:0] w_mem_nxt;

  logic                       w_gnt;
  logic                       w_addr_is_word;
  logic [31:0]                w_rd_word;
  logic [31:0]                w_status;
  logic                       w_wr_word;
  logic                       w_set_seal;
  logic                       w_rsp_err;
  logic [31:0]                w_rsp_data;
  logic                       w_force_ones;

  logic                       r_rvalid;
  logic [31:0]                r_rdata;
  logic                       r_err;

  // The grant is suppressed during the single CLEAR cycle. This prevents a
  // write from racing the wipe.
  assign w_gnt          = bus.req_i && (r_state != ST_CLEAR);
  assign w_addr_is_word = (32'(bus.addr_i) < NUM_WORDS);
  assign w_status       = {28'h0, r_lockout, (r_state != ST_IDLE),
                           (r_fail_cnt != 2'd0), r_seal};

  // Read mux for lock words, built as an AND-OR so out-of-range addresses return zero.
  always_comb begin
    w_rd_word = 32'h0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w_rd_word = w_rd_word | ({32{bus.addr_i == 3'(k)}} & r_mem[k]);
    end
  end

  // Bus decode: classifies the granted access and builds the response.
  always_comb begin
    w_wr_word  = 1'b0;
    w_set_seal = 1'b0;
    w_rsp_err  = 1'b0;
    w_rsp_data = 32'h0;
    if (w_gnt) begin
      if (bus.we_i) begin
        if (w_addr_is_word) begin
          if (r_seal) begin
            w_rsp_err = 1'b1;
          end else begin
            w_wr_word = 1'b1;
          end
        end else if (bus.addr_i == CTRL_ADDR) begin
          if (r_seal) begin
            w_rsp_err = 1'b1;
          end else begin
            w_set_seal = bus.wdata_i[0];
          end
        end else begin
          w_rsp_err = 1'b1;
        end
      end else begin
        if (w_addr_is_word) begin
          w_rsp_data = w_rd_word;
        end else if (bus.addr_i == CTRL_ADDR) begin
          w_rsp_data = w_status;
        end else begin
          w_rsp_err = 1'b1;
        end
      end
    end else begin
      w_rsp_err = 1'b0;
    end
  end

  // Unlock FSM next-state logic. A request drop aborts the attempt. A key
  // strobe is checked before the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (jtag_unlock_req_i && !r_need_low) begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = TIMER_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!jtag_unlock_req_i) begin
          w_state_nxt = ST_IDLE;
        end else if (jtag_key_valid_i) begin
          if (jtag_key_i == UNLOCK_KEY) begin
            w_state_nxt = ST_CLEAR;
          end else begin
            w_state_nxt = ST_FAIL;
          end
        end else if (r_timer == {TW{1'b0}}) begin
          w_state_nxt = ST_FAIL;
        end else begin
          w_timer_nxt = r_timer - {{(TW-1){1'b0}}, 1'b1};
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_IDLE;
      end
      ST_FAIL: begin
        if (r_fail_cnt >= FAIL_LIMIT) begin
          w_state_nxt = ST_LOCKOUT;
        end else if (!jtag_unlock_req_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FAIL;
        end
      end
      ST_LOCKOUT: begin
        w_state_nxt = ST_LOCKOUT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next lock-word values. Fail-secure forcing wins, then the unlock wipe, then sticky bus sets.
  always_comb begin
    w_mem_nxt = r_mem;
    if (w_force_ones) begin
      w_mem_nxt = {NUM_WORDS{32'hFFFF_FFFF}};
    end else if (r_state == ST_CLEAR) begin
      w_mem_nxt = {NUM_WORDS{32'h0000_0000}};
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        w_mem_nxt[k] = r_mem[k] |
                       ({32{w_wr_word && (bus.addr_i == 3'(k))}} & bus.wdata_i);
      end
    end
  end

  // FSM state, attempt timer and the re-arm flag that is set after a successful unlock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_timer    <= {TW{1'b0}};
      r_need_low <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      if (r_state == ST_CLEAR) begin
        r_need_low <= 1'b1;
      end else if (!jtag_unlock_req_i) begin
        r_need_low <= 1'b0;
      end else begin
        r_need_low <= r_need_low;
      end
    end
  end

  // Failure counter: it counts once on each entry into FAIL, saturates, and is wiped by CLEAR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fail_cnt <= 2'd0;
    end else if (r_state == ST_CLEAR) begin
      r_fail_cnt <= 2'd0;
    end else if ((w_state_nxt == ST_FAIL) && (r_state != ST_FAIL) &&
                 (r_fail_cnt != 2'd3)) begin
      r_fail_cnt <= r_fail_cnt + 2'd1;
    end else begin
      r_fail_cnt <= r_fail_cnt;
    end
  end

  // Lock array and sticky seal.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem  <= {NUM_WORDS{32'h0000_0000}};
      r_seal <= 1'b0;
    end else begin
      r_mem <= w_mem_nxt;
      if (r_state == ST_CLEAR) begin
        r_seal <= 1'b0;
      end else if (w_set_seal) begin
        r_seal <= 1'b1;
      end else begin
        r_seal <= r_seal;
      end
    end
  end

  // Registered bus response and JTAG status outputs. Reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid      <= 1'b0;
      r_rdata       <= 32'h0;
      r_err         <= 1'b0;
      r_unlock_done <= 1'b0;
      r_lockout     <= 1'b0;
    end else begin
      r_rvalid      <= w_gnt;
      r_rdata       <= w_rsp_data;
      r_err         <= w_rsp_err;
      r_unlock_done <= (w_state_nxt == ST_CLEAR);
      r_lockout     <= (w_state_nxt == ST_LOCKOUT);
    end
  end

`ifdef REGLK_PARITY_EN
  logic [NUM_WORDS-1:0] r_par;
  logic                 w_par_mis;
  logic                 r_parity_err;

  function automatic logic parity32(input logic [31:0] d);
    return ^d;
  endfunction

  // Parity check: compares every stored word against its stored parity bit on each cycle.
  always_comb begin
    w_par_mis = 1'b0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w_par_mis = w_par_mis | (parity32(r_mem[k]) != r_par[k]);
    end
  end

  // Parity storage follows every word update. The error flag stays set until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_par        <= {NUM_WORDS{1'b0}};
      r_parity_err <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_par[k] <= parity32(w_mem_nxt[k]);
      end
      r_parity_err <= r_parity_err | w_par_mis;
    end
  end

  assign w_force_ones       = w_par_mis | r_parity_err;
  assign reglk_parity_err_o = r_parity_err;
`else
  assign w_force_ones       = 1'b0;
  assign reglk_parity_err_o = 1'b0;
`endif

  assign bus.gnt_o     = w_gnt;
  assign bus.rvalid_o  = r_rvalid;
  assign bus.rdata_o   = r_rdata;
  assign bus.err_o     = r_err;
  assign unlock_done_o = r_unlock_done;
  assign lockout_o     = r_lockout;
  assign reglk_mem_o   = r_mem;

endmodule

// File: tb/tb_reglk_prog_ctrl.sv
// Scoreboard bench for reglk_prog_ctrl. The bench pushes expected responses
// when a request is granted, and a monitor pops and compares them on each rvalid.
module tb_reglk_prog_ctrl;

  localparam logic [31:0] KEY = 32'hA5C3_5A3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jtag_req = 1'b0;
  logic jtag_kv = 1'b0;
  logic [31:0] jtag_key = 32'h0;
  logic unlock_done;
  logic lockout;
  logic par_err;
  logic [5:0][31:0] mem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  reglk_prog_ctrl_if bif ();

  reglk_prog_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .bus                (bif),
    .jtag_unlock_req_i  (jtag_req),
    .jtag_key_valid_i   (jtag_kv),
    .jtag_key_i         (jtag_key),
    .unlock_done_o      (unlock_done),
    .lockout_o          (lockout),
    .reglk_parity_err_o (par_err),
    .reglk_mem_o        (mem)
  );

  always #5 clk = ~clk;

  // Cycle stamp used to check the one-cycle response latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one request from a negedge, waits (bounded) for the grant, and queues the expected response.
  task automatic bus_op(input logic we, input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee);
    int n;
    exp_t e;
    n = 0;
    bif.req_i   = 1'b1;
    bif.we_i    = we;
    bif.addr_i  = a;
    bif.wdata_i = d;
    #1;
    while (!bif.gnt_o && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bif.gnt_o) begin
      e.data = er;
      e.err  = ee;
      e.cyc  = cyc;
      exp_q.push_back(e);
    end else begin
      check_eq("gnt_timeout", 192'(bif.gnt_o), 192'(1'b1));
    end
    @(negedge clk);
    bif.req_i = 1'b0;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (bif.rvalid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rsp", 192'(bif.rvalid_o), 192'(1'b0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rsp_latency", 192'(cyc), 192'(e.cyc + 1));
        check_eq("rsp_rdata", 192'(bif.rdata_o), 192'(e.data));
        check_eq("rsp_err", 192'(bif.err_o), 192'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [5:0] p;
    bif.req_i   = 1'b0;
    bif.we_i    = 1'b0;
    bif.addr_i  = 3'd0;
    bif.wdata_i = 32'h0;

    repeat (2) @(negedge clk);
    check_eq("rst_rvalid", 192'(bif.rvalid_o), 192'(1'b0));
    check_eq("rst_rdata", 192'(bif.rdata_o), 192'(32'h0));
    check_eq("rst_err", 192'(bif.err_o), 192'(1'b0));
    check_eq("rst_done", 192'(unlock_done), 192'(1'b0));
    check_eq("rst_lockout", 192'(lockout), 192'(1'b0));
    check_eq("rst_parerr", 192'(par_err), 192'(1'b0));
    check_eq("rst_mem", 192'(mem), 192'(0));
    rst = 1'b0;
    @(negedge clk);

    // Sticky-set writes and readback.
    bus_op(1'b1, 3'd0, 32'h0000_00F0, 32'h0, 1'b0);
    bus_op(1'b1, 3'd0, 32'h0000_000F, 32'h0, 1'b0);
    bus_op(1'b0, 3'd0, 32'h0, 32'h0000_00FF, 1'b0);
    bus_op(1'b1, 3'd2, 32'h1234_5678, 32'h0, 1'b0);
    bus_op(1'b0, 3'd2, 32'h0, 32'h1234_5678, 1'b0);

    // Seal, then the sealed write is refused.
    bus_op(1'b1, 3'd6, 32'h0000_0001, 32'h0, 1'b0);
    bus_op(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    bus_op(1'b0, 3'd1, 32'h0, 32'h0, 1'b0);
    bus_op(1'b0, 3'd6, 32'h0, 32'h0000_0001, 1'b0);

    // Correct-key unlock after three cycles in WAIT_KEY.
    jtag_req = 1'b1;
    repeat (3) @(negedge clk);
    jtag_kv  = 1'b1;
    jtag_key = KEY;
    @(negedge clk);
    jtag_kv = 1'b0;
    check_eq("unlock_pulse", 192'(unlock_done), 192'(1'b1));
    bif.req_i  = 1'b1;
    bif.we_i   = 1'b0;
    bif.addr_i = 3'd0;
    #1;
    check_eq("gnt_in_clear", 192'(bif.gnt_o), 192'(1'b0));
    bus_op(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    check_eq("unlock_pulse_end", 192'(unlock_done), 192'(1'b0));
    check_eq("mem_cleared", 192'(mem), 192'(0));
    bus_op(1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
    jtag_req = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout with no key leads to FAIL with fail_cnt = 1.
    jtag_req = 1'b1;
    repeat (20) @(negedge clk);
    bus_op(1'b0, 3'd6, 32'h0, 32'h0000_0006, 1'b0);
    jtag_req = 1'b0;
    repeat (2) @(negedge clk);

    // Key on the cycle the timer reaches 0 still unlocks and clears fail_cnt.
    jtag_req = 1'b1;
    repeat (16) @(negedge clk);
    jtag_kv  = 1'b1;
    jtag_key = KEY;
    @(negedge clk);
    jtag_kv = 1'b0;
    check_eq("unlock_at_timer0", 192'(unlock_done), 192'(1'b1));
    jtag_req = 1'b0;
    @(negedge clk);
    bus_op(1'b0, 3'd6, 32'h0, 32'h0, 1'b0);

    // Three wrong-key attempts lead to lockout.
    for (int i = 0; i < 3; i++) begin
      jtag_req = 1'b1;
      repeat (2) @(negedge clk);
      jtag_kv  = 1'b1;
      jtag_key = 32'h0;
      @(negedge clk);
      jtag_kv = 1'b0;
      @(negedge clk);
      jtag_req = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("lockout_after_attempt", 192'(lockout), 192'(i == 2));
    end
    bus_op(1'b0, 3'd6, 32'h0, 32'h0000_000E, 1'b0);

    // A correct key during lockout has no effect.
    jtag_req = 1'b1;
    repeat (2) @(negedge clk);
    jtag_kv  = 1'b1;
    jtag_key = KEY;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      jtag_kv = 1'b0;
      seen = seen | unlock_done;
    end
    check_eq("no_unlock_in_lockout", 192'(seen), 192'(1'b0));
    check_eq("lockout_held", 192'(lockout), 192'(1'b1));
    jtag_req = 1'b0;

    // The bus keeps working during lockout, and the error addresses are refused.
    bus_op(1'b1, 3'd3, 32'h0000_0005, 32'h0, 1'b0);
    bus_op(1'b0, 3'd7, 32'h0, 32'h0, 1'b1);
    bus_op(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 1'b1);
    bus_op(1'b1, 3'd6, 32'h0000_0000, 32'h0, 1'b0);
    bus_op(1'b0, 3'd6, 32'h0, 32'h0000_000E, 1'b0);
    bus_op(1'b1, 3'd6, 32'h0000_0001, 32'h0, 1'b0);
    bus_op(1'b1, 3'd6, 32'h0000_0001, 32'h0, 1'b1);
    bus_op(1'b1, 3'd3, 32'h0000_00F0, 32'h0, 1'b1);
    bus_op(1'b0, 3'd3, 32'h0, 32'h0000_0005, 1'b0);
    repeat (2) @(negedge clk);

    // Global reset clears the lockout, the seal and the words.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst2_lockout", 192'(lockout), 192'(1'b0));
    check_eq("rst2_mem", 192'(mem), 192'(0));
    @(negedge clk);
    bus_op(1'b0, 3'd6, 32'h0, 32'h0, 1'b0);

`ifdef REGLK_PARITY_EN
    bus_op(1'b1, 3'd0, 32'h0000_0003, 32'h0, 1'b0);
    p = dut.r_par;
    force dut.r_par = p ^ 6'b00_0001;
    @(negedge clk);
    check_eq("parity_err", 192'(par_err), 192'(1'b1));
    check_eq("parity_fail_secure", 192'(mem), {6{32'hFFFF_FFFF}});
    release dut.r_par;
    repeat (2) @(negedge clk);
    check_eq("parity_err_sticky", 192'(par_err), 192'(1'b1));
`else
    p = 6'b0;
    check_eq("parity_tied_off", 192'(par_err), 192'(p[0]));
`endif

    repeat (2) @(negedge clk);
    check_eq("rsp_pending", 192'(exp_q.size()), 192'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reglk_prog_ctrl.md
Name: reglk_prog_ctrl

Overview:
- Upstream programming stage for the register-lock bank: owns and drives the NUM_WORDS x 32 lock-bit array consumed by peripheral register write-guards.
- Provides a bus port for reading and setting lock bits with sticky-set semantics, plus a one-shot seal.
- Clearing is possible only through global reset or a key-authenticated JTAG unlock handled by an internal FSM with timeout and lockout.
- No block-local reset exists, so the locks cannot be cleared at runtime independently of the system.

Parameters:
- NUM_WORDS, 6, number of 32-bit lock words (1..6).
- UNLOCK_KEY, 32'hA5C3_5A3C, JTAG key required to clear locks.
- UNLOCK_TIMEOUT, 16, cycles allowed in WAIT_KEY before the attempt fails (>=1).
- MAX_FAILS, 3, failed attempts before permanent lockout (1..3).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  bus request.
- we_i  in  1  1=write, 0=read.
- addr_i  in  3  word address.
- wdata_i  in  32  write data (bits to set).
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- err_o  out  1  response error, valid with rvalid_o.
- jtag_unlock_req_i  in  1  level, JTAG requests unlock.
- jtag_key_valid_i  in  1  key strobe.
- jtag_key_i  in  32  key value.
- unlock_done_o  out  1  one-cycle pulse when locks are cleared.
- lockout_o  out  1  sticky, unlock permanently refused until rst_i.
- reglk_parity_err_o  out  1  parity error flag (see Optional Feature).
- reglk_mem_o  out  NUM_WORDS x 32  lock words to downstream guards, registered.

Behaviour:
- Reset (rst_i=1 at clk edge): all reglk_mem_o=0, seal=0, FSM=IDLE, fail_cnt=0, timeout counter=0. Outputs gnt_o, rvalid_o, rdata_o, err_o, unlock_done_o, lockout_o, reglk_parity_err_o all 0. Reset mid-transaction drops any pending response.
- gnt_o = req_i when FSM is not CLEAR; combinational. In CLEAR, gnt_o=0 and the requester holds req_i.
- Response latency is 1 cycle: a grant in cycle N gives rvalid_o=1 in N+1 with rdata_o and err_o. Back-to-back requests are accepted every cycle.
- Write, addr<NUM_WORDS, not sealed: word <= word | wdata_i; err_o=0. Bits are never cleared by the bus.
- Write while sealed: err_o=1, no state change.
- Write, addr=6: wdata_i[0]=1 sets seal (sticky); wdata_i[0]=0 has no effect; err_o=0. If already sealed, err_o=1.
- Read, addr<NUM_WORDS: rdata_o=word (value before any same-cycle write).
- Read, addr=6: rdata_o={28'b0, lockout, fsm!=IDLE, fail_cnt>0, seal}.
- Any other address (NUM_WORDS..5, or 7): err_o=1, rdata_o=0, no state change. rdata_o=0 on every write response.
- FSM states: IDLE, WAIT_KEY, CLEAR, FAIL, LOCKOUT.
  - IDLE: jtag_unlock_req_i=1 -> WAIT_KEY, timer=UNLOCK_TIMEOUT-1.
  - WAIT_KEY: key_valid with key==UNLOCK_KEY -> CLEAR. Wrong key -> FAIL. Otherwise, timer==0 -> FAIL, else timer decrements. Key check takes priority over timeout in the same cycle. jtag_unlock_req_i dropping -> IDLE with no fail counted.
  - CLEAR: exactly 1 cycle. All words=0, seal=0, fail_cnt=0, unlock_done_o=1 in that cycle's registered output. Next state IDLE, and a new attempt starts only after jtag_unlock_req_i has been seen low.
  - FAIL: fail_cnt++ on entry (saturating). If fail_cnt reaches MAX_FAILS -> LOCKOUT. Otherwise remain in FAIL until jtag_unlock_req_i=0, then IDLE.
  - LOCKOUT: absorbing until rst_i; lockout_o=1. The bus keeps operating normally.
- A bus write granted in the same cycle the FSM enters CLEAR cannot occur, because the grant is suppressed in CLEAR.

Optional Feature:
- Macro REGLK_PARITY_EN.
- With the macro: a parity bit per word is updated on every change. Stored parity is checked against the word every cycle. A mismatch sets reglk_parity_err_o (sticky until rst_i) and forces every word to all-ones (fail-secure) on the next cycle.
- Without the macro: no parity storage, and reglk_parity_err_o is tied to 0.

Test Plan:
- Reset then write addr0 32'h0000_00F0, then write addr0 32'h0000_000F, then read addr0 -> rdata_o=32'h0000_00FF, err_o=0, rvalid_o one cycle after each grant.
- Write addr6 32'h1, then write addr1 32'hFFFF_FFFF -> second write err_o=1; read addr1 returns 0; read addr6 returns 32'h1.
- Set addr2 32'h1234_5678 and seal, then jtag_unlock_req_i=1 with key 32'hA5C3_5A3C after 3 cycles -> unlock_done_o pulses, gnt_o=0 for 1 cycle, all words 0, seal 0.
- Run 3 attempts with wrong key 32'h0 (dropping the request between attempts) -> lockout_o=1 after the third; a 4th attempt with the correct key has no effect; rst_i clears lockout_o.
- Assert request with no key for 16 cycles -> FAIL, fail_cnt=1 (addr6 bit1=1). Correct key on the cycle the timer hits 0 -> CLEAR.
- Read addr7 and write addr6 while sealed -> err_o=1, rdata_o=0. With REGLK_PARITY_EN, force a bit flip in a word -> reglk_parity_err_o=1 and words all 32'hFFFF_FFFF next cycle.
